// File: rtl/video_tpg_axis.sv
// AXI4-Stream video test-pattern generator: colour bars, ramp, checkerboard or solid colour.
// Optional build macro TPG_SCROLL_EN adds a per-frame horizontal scroll to patterns 0-2.
module video_tpg_axis #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic [23:0] m_tdata,
  output logic        m_tuser,
  output logic        m_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        busy,
  output logic        frame_done
);

  localparam int XW    = $clog2(H_ACTIVE);
  localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BW    = (H_BLANK > 0) ? $clog2(H_BLANK + 1) : 1;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int SW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(H_BLANK - 1);
  localparam logic [SW-1:0] S_LAST = SW'(BAR_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LINE   = 2'd1,
    ST_HBLANK = 2'd2
  } state_t;

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      3'd7:    bar_rgb = 24'h000000;
      default: bar_rgb = 24'h000000;
    endcase
  endfunction

  // Eight bars of BAR_W pixels tile a line exactly, so the 3-bit index wraps with x.
  function automatic logic [SW+2:0] bar_step(input logic [2:0] bar, input logic [SW-1:0] sub);
    if (sub == S_LAST) begin
      bar_step = {bar + 3'd1, {SW{1'b0}}};
    end else begin
      bar_step = {bar, sub + SW'(1)};
    end
  endfunction

  function automatic logic [23:0] pix(input logic [1:0] pat, input logic [7:0] sx,
                                      input logic yb4, input logic [2:0] bar,
                                      input logic [23:0] solid);
    case (pat)
      2'd0:    pix = bar_rgb(bar);
      2'd1:    pix = {sx, sx, sx};
      2'd2:    pix = (sx[4] ^ yb4) ? 24'hFFFFFF : 24'h000000;
      2'd3:    pix = solid;
      default: pix = 24'h000000;
    endcase
  endfunction

  state_t        state_r, state_s;
  logic [XW-1:0] x_r, x_s;
  logic [YW-1:0] y_r, y_s;
  logic [BW-1:0] bcnt_r, bcnt_s;
  logic [2:0]    bar_r, bar_s;
  logic [SW-1:0] sub_r, sub_s;
  logic [1:0]    pat_r, pat_s;
  logic [23:0]   solid_r, solid_s;
  logic          last_line_r, last_line_s;
  logic [23:0]   tdata_s;
  logic          tuser_s, tlast_s, tvalid_s, busy_s, frame_done_s, load_s;
  logic [2:0]    line_bar_s;
  logic [SW-1:0] line_sub_s;
  logic [7:0]    fc_s;
  logic [7:0]    sx_s;
  logic          yb4_s;

`ifdef TPG_SCROLL_EN
  logic [7:0]    frame_cnt_r;
  logic [2:0]    start_bar_r;
  logic [SW-1:0] start_sub_r;

  // Scroll offset: advances one pixel per completed frame, restarts when the count wraps
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt_r <= 8'd0;
      start_bar_r <= 3'd0;
      start_sub_r <= {SW{1'b0}};
    end else if (frame_done_s) begin
      frame_cnt_r <= frame_cnt_r + 8'd1;
      if (frame_cnt_r == 8'd255) begin
        start_bar_r <= 3'd0;
        start_sub_r <= {SW{1'b0}};
      end else begin
        {start_bar_r, start_sub_r} <= bar_step(start_bar_r, start_sub_r);
      end
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign fc_s       = frame_cnt_r;
  assign line_bar_s = start_bar_r;
  assign line_sub_s = start_sub_r;
`else
  assign fc_s       = 8'd0;
  assign line_bar_s = 3'd0;
  assign line_sub_s = {SW{1'b0}};
`endif

  assign sx_s = 8'(x_s) + fc_s;

  if (YW > 4) begin : g_yb4
    assign yb4_s = y_s[4];
  end else begin : g_yb4_zero
    assign yb4_s = 1'b0;
  end

  // Next-state and counter update; load_s marks cycles where a new beat is presented
  always_comb begin
    state_s      = state_r;
    x_s          = x_r;
    y_s          = y_r;
    bcnt_s       = bcnt_r;
    bar_s        = bar_r;
    sub_s        = sub_r;
    pat_s        = pat_r;
    solid_s      = solid_r;
    last_line_s  = last_line_r;
    tvalid_s     = m_tvalid;
    busy_s       = busy;
    frame_done_s = 1'b0;
    load_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en) begin
          pat_s       = pattern_sel;
          solid_s     = solid_rgb;
          x_s         = {XW{1'b0}};
          y_s         = {YW{1'b0}};
          bar_s       = line_bar_s;
          sub_s       = line_sub_s;
          last_line_s = 1'b0;
          state_s     = ST_LINE;
          tvalid_s    = 1'b1;
          busy_s      = 1'b1;
          load_s      = 1'b1;
        end else begin
          tvalid_s = 1'b0;
          busy_s   = 1'b0;
        end
      end
      ST_LINE: begin
        if (m_tvalid && m_tready) begin
          if (x_r == X_LAST) begin
            x_s          = {XW{1'b0}};
            bar_s        = line_bar_s;
            sub_s        = line_sub_s;
            last_line_s  = (y_r == Y_LAST);
            frame_done_s = (y_r == Y_LAST);
            if (y_r == Y_LAST) begin
              y_s = {YW{1'b0}};
            end else begin
              y_s = y_r + YW'(1);
            end
            if (H_BLANK != 0) begin
              state_s  = ST_HBLANK;
              bcnt_s   = {BW{1'b0}};
              tvalid_s = 1'b0;
            end else if (y_r == Y_LAST) begin
              state_s  = ST_IDLE;
              tvalid_s = 1'b0;
              busy_s   = 1'b0;
            end else begin
              load_s = 1'b1;
            end
          end else begin
            x_s            = x_r + XW'(1);
            {bar_s, sub_s} = bar_step(bar_r, sub_r);
            load_s         = 1'b1;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      ST_HBLANK: begin
        if (bcnt_r == B_LAST) begin
          if (last_line_r) begin
            state_s  = ST_IDLE;
            tvalid_s = 1'b0;
            busy_s   = 1'b0;
          end else begin
            state_s  = ST_LINE;
            tvalid_s = 1'b1;
            load_s   = 1'b1;
          end
        end else begin
          bcnt_s = bcnt_r + BW'(1);
        end
      end
      default: begin
        state_s  = ST_IDLE;
        tvalid_s = 1'b0;
        busy_s   = 1'b0;
      end
    endcase
  end

  // Pixel, SOF and EOL for the beat about to be presented; otherwise hold the current beat
  always_comb begin
    if (load_s) begin
      tdata_s = pix(pat_s, sx_s, yb4_s, bar_s, solid_s);
      tuser_s = (x_s == {XW{1'b0}}) && (y_s == {YW{1'b0}});
      tlast_s = (x_s == X_LAST);
    end else begin
      tdata_s = m_tdata;
      tuser_s = m_tuser;
      tlast_s = m_tlast;
    end
  end

  // State, counters and registered stream outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      x_r         <= {XW{1'b0}};
      y_r         <= {YW{1'b0}};
      bcnt_r      <= {BW{1'b0}};
      bar_r       <= 3'd0;
      sub_r       <= {SW{1'b0}};
      pat_r       <= 2'd0;
      solid_r     <= 24'd0;
      last_line_r <= 1'b0;
      m_tdata     <= 24'd0;
      m_tuser     <= 1'b0;
      m_tlast     <= 1'b0;
      m_tvalid    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_r     <= state_s;
      x_r         <= x_s;
      y_r         <= y_s;
      bcnt_r      <= bcnt_s;
      bar_r       <= bar_s;
      sub_r       <= sub_s;
      pat_r       <= pat_s;
      solid_r     <= solid_s;
      last_line_r <= last_line_s;
      m_tdata     <= tdata_s;
      m_tuser     <= tuser_s;
      m_tlast     <= tlast_s;
      m_tvalid    <= tvalid_s;
      busy        <= busy_s;
      frame_done  <= frame_done_s;
    end
  end

endmodule

// File: tb/tb_video_tpg_axis.sv
// Self-checking bench for video_tpg_axis: 16x4 frames, 2 blanking cycles, random backpressure.
`timescale 1ns/1ps
module tb_video_tpg_axis;
  localparam int H    = 16;
  localparam int V    = 4;
  localparam int HB   = 2;
  localparam int FB   = H * V;
  localparam int MAXC = 3000;
`ifdef TPG_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] solid_rgb = 24'd0;
  logic [23:0] m_tdata;
  logic        m_tuser, m_tlast, m_tvalid, busy, frame_done;
  logic        m_tready = 1'b0;

  video_tpg_axis #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB)) dut (
    .clk(clk), .rstn(rstn), .en(en), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int fc_model = 0;
  logic [23:0] bar_tab [8];

  logic        tr_valid [MAXC];
  logic        tr_ready [MAXC];
  logic        tr_user  [MAXC];
  logic        tr_last  [MAXC];
  logic        tr_busy  [MAXC];
  logic        tr_fd    [MAXC];
  logic [23:0] tr_data  [MAXC];
  int          n_cyc;
  logic [23:0] b_data [$];
  logic        b_user [$];
  logic        b_last [$];

  function automatic logic [23:0] ref_pixel(input int pat, input int x, input int y,
                                            input logic [23:0] solid, input int fc);
    int sx;
    logic [7:0] v;
    sx = SCROLL ? (x + fc) : x;
    v  = sx[7:0];
    case (pat)
      0:       ref_pixel = bar_tab[(sx % H) / (H / 8)];
      1:       ref_pixel = {v, v, v};
      2:       ref_pixel = (((sx >> 4) ^ (y >> 4)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
      default: ref_pixel = solid;
    endcase
  endfunction

  // Records one sample per cycle (at negedge) until nframes frames are done and busy drops.
  task automatic capture(input int nframes, input int ready_pct, input int drop_at,
                         input int chg_at, input logic [1:0] chg_pat,
                         input logic [23:0] chg_rgb, output bit to);
    int fd_seen;
    int acc;
    bit done;
    n_cyc = 0; fd_seen = 0; acc = 0; to = 1'b0; done = 1'b0;
    b_data.delete(); b_user.delete(); b_last.delete();
    while (!done) begin
      @(negedge clk);
      if (n_cyc >= MAXC) begin
        to = 1'b1;
        done = 1'b1;
      end else begin
        m_tready = (int'($urandom_range(99, 0)) < ready_pct) ? 1'b1 : 1'b0;
        tr_valid[n_cyc] = m_tvalid; tr_ready[n_cyc] = m_tready; tr_user[n_cyc] = m_tuser;
        tr_last[n_cyc] = m_tlast; tr_busy[n_cyc] = busy; tr_fd[n_cyc] = frame_done;
        tr_data[n_cyc] = m_tdata;
        if (m_tvalid && m_tready) begin
          b_data.push_back(m_tdata); b_user.push_back(m_tuser); b_last.push_back(m_tlast);
          acc++;
          if (acc == drop_at) en = 1'b0;
          if (acc == chg_at) begin
            pattern_sel = chg_pat;
            solid_rgb   = chg_rgb;
          end
        end
        if (frame_done) fd_seen++;
        n_cyc++;
        if (fd_seen >= nframes && !busy) done = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b0; m_tready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({m_tvalid, m_tuser, m_tlast, busy, frame_done, m_tdata} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0", {m_tvalid, m_tuser, m_tlast, busy, frame_done, m_tdata});
    end
    rstn = 1'b1;
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle tvalid=%b busy=%b exp 0/0", m_tvalid, busy);
      end
    end
  endtask

  task automatic test_bars();
    bit to;
    int k_last, fds, idle;
    logic [23:0] exp;
    pattern_sel = 2'd0; en = 1'b1;
    capture(1, 100, 10, -1, 2'd0, 24'd0, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL bars_timeout cycles=%0d exp frame end", n_cyc); end
    n_checks++;
    if (b_data.size() != FB) begin n_fail++; $display("FAIL bars_count got=%0d exp=%0d", b_data.size(), FB); end
    for (int i = 0; i < b_data.size() && i < FB; i++) begin
      exp = ref_pixel(0, i % H, i / H, 24'd0, fc_model);
      n_checks++;
      if (b_data[i] !== exp || b_user[i] !== (i == 0) || b_last[i] !== (i % H == H - 1)) begin
        n_fail++;
        $display("FAIL bars_beat i=%0d got=%h/%b/%b exp=%h/%b/%b", i, b_data[i], b_user[i], b_last[i],
                 exp, (i == 0), (i % H == H - 1));
      end
    end
    k_last = -1; fds = 0;
    for (int k = 0; k < n_cyc; k++) begin
      if (tr_fd[k]) fds++;
      if (tr_valid[k] && tr_ready[k]) begin
        k_last = k;
        if (tr_last[k]) begin
          idle = 0;
          for (int j = k + 1; j < n_cyc && !tr_valid[j] && tr_busy[j]; j++) idle++;
          n_checks++;
          if (idle != HB) begin n_fail++; $display("FAIL bars_hblank cyc=%0d got=%0d exp=%0d", k, idle, HB); end
        end
      end
    end
    n_checks++;
    if (fds != 1) begin n_fail++; $display("FAIL bars_frame_done_count got=%0d exp=1", fds); end
    n_checks++;
    if (k_last < 0 || k_last + 1 >= n_cyc || tr_fd[k_last + 1] !== 1'b1) begin
      n_fail++; $display("FAIL bars_frame_done_timing last_beat_cyc=%0d exp pulse next cycle", k_last);
    end
    fc_model += 1;
  endtask

  task automatic test_ramp_backpressure();
    bit to;
    logic [23:0] exp;
    pattern_sel = 2'd1; en = 1'b1;
    capture(1, 50, 10, -1, 2'd0, 24'd0, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL ramp_timeout cycles=%0d exp frame end", n_cyc); end
    n_checks++;
    if (b_data.size() != FB) begin n_fail++; $display("FAIL ramp_count got=%0d exp=%0d", b_data.size(), FB); end
    for (int i = 0; i < b_data.size() && i < FB; i++) begin
      exp = ref_pixel(1, i % H, i / H, 24'd0, fc_model);
      n_checks++;
      if (b_data[i] !== exp || b_user[i] !== (i == 0) || b_last[i] !== (i % H == H - 1)) begin
        n_fail++;
        $display("FAIL ramp_beat i=%0d got=%h/%b/%b exp=%h/%b/%b", i, b_data[i], b_user[i], b_last[i],
                 exp, (i == 0), (i % H == H - 1));
      end
    end
    for (int k = 0; k + 1 < n_cyc; k++) begin
      if (tr_valid[k] && !tr_ready[k]) begin
        n_checks++;
        if (tr_valid[k + 1] !== 1'b1 || tr_data[k + 1] !== tr_data[k] ||
            tr_user[k + 1] !== tr_user[k] || tr_last[k + 1] !== tr_last[k]) begin
          n_fail++;
          $display("FAIL ramp_stall_hold cyc=%0d got=%b/%h exp=1/%h", k, tr_valid[k + 1], tr_data[k + 1], tr_data[k]);
        end
      end
    end
    fc_model += 1;
  endtask

  task automatic test_solid_latch();
    bit to;
    int fds;
    logic [23:0] exp;
    pattern_sel = 2'd3; solid_rgb = 24'h123456; en = 1'b1;
    capture(2, 70, FB + 10, 20, 2'd2, 24'hABCDEF, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL solid_timeout cycles=%0d exp frame end", n_cyc); end
    n_checks++;
    if (b_data.size() != 2 * FB) begin n_fail++; $display("FAIL solid_count got=%0d exp=%0d", b_data.size(), 2 * FB); end
    for (int i = 0; i < b_data.size() && i < 2 * FB; i++) begin
      if (i < FB) exp = 24'h123456;
      else exp = ref_pixel(2, (i - FB) % H, (i - FB) / H, 24'hABCDEF, fc_model + 1);
      n_checks++;
      if (b_data[i] !== exp || b_user[i] !== (i % FB == 0)) begin
        n_fail++;
        $display("FAIL solid_beat i=%0d got=%h/%b exp=%h/%b", i, b_data[i], b_user[i], exp, (i % FB == 0));
      end
    end
    fds = 0;
    for (int k = 0; k < n_cyc; k++) if (tr_fd[k]) fds++;
    n_checks++;
    if (fds != 2) begin n_fail++; $display("FAIL solid_frame_done_count got=%0d exp=2", fds); end
    fc_model += 2;
  endtask

  task automatic test_en_drop();
    bit to;
    logic [23:0] exp;
    pattern_sel = 2'd2; en = 1'b1;
    capture(1, 80, 10, -1, 2'd0, 24'd0, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL endrop_timeout cycles=%0d exp frame end", n_cyc); end
    n_checks++;
    if (b_data.size() != FB) begin n_fail++; $display("FAIL endrop_count got=%0d exp=%0d", b_data.size(), FB); end
    for (int i = 0; i < b_data.size() && i < FB; i++) begin
      exp = ref_pixel(2, i % H, i / H, 24'd0, fc_model);
      n_checks++;
      if (b_data[i] !== exp || b_last[i] !== (i % H == H - 1)) begin
        n_fail++; $display("FAIL endrop_beat i=%0d got=%h/%b exp=%h/%b", i, b_data[i], b_last[i], exp, (i % H == H - 1));
      end
    end
    fc_model += 1;
    repeat (20) begin
      @(negedge clk);
      n_checks++;
      if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL endrop_stays_idle tvalid=%b busy=%b exp 0/0", m_tvalid, busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int acc, cyc;
    logic [23:0] exp;
    pattern_sel = 2'd1; en = 1'b1; m_tready = 1'b1;
    acc = 0; cyc = 0;
    while (acc < 5 && cyc < 200) begin
      @(negedge clk);
      if (m_tvalid && m_tready) acc++;
      cyc++;
    end
    n_checks++;
    if (acc < 5) begin n_fail++; $display("FAIL rstmid_start got=%0d beats exp=5", acc); end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({m_tvalid, m_tuser, m_tlast, busy, frame_done, m_tdata} !== 29'd0) begin
      n_fail++; $display("FAIL rstmid_async_clear got=%h exp=0", {m_tvalid, m_tuser, m_tlast, busy, m_tdata});
    end
    fc_model = 0;
    @(negedge clk);
    n_checks++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_held tvalid=%b busy=%b exp 0/0", m_tvalid, busy);
    end
    rstn = 1'b1;
    capture(1, 100, 10, -1, 2'd0, 24'd0, to);
    n_checks++;
    if (to || b_data.size() != FB) begin
      n_fail++; $display("FAIL rstmid_count got=%0d exp=%0d timeout=%b", b_data.size(), FB, to);
    end
    for (int i = 0; i < b_data.size() && i < FB; i++) begin
      exp = ref_pixel(1, i % H, i / H, 24'd0, fc_model);
      n_checks++;
      if (b_data[i] !== exp || b_user[i] !== (i == 0)) begin
        n_fail++; $display("FAIL rstmid_beat i=%0d got=%h/%b exp=%h/%b", i, b_data[i], b_user[i], exp, (i == 0));
      end
    end
    fc_model += 1;
  endtask

  task automatic test_scroll();
    bit to;
    logic [23:0] exp2;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    fc_model = 0;
    pattern_sel = 2'd1; en = 1'b1;
    capture(2, 100, FB + 10, -1, 2'd0, 24'd0, to);
    n_checks++;
    if (to || b_data.size() != 2 * FB) begin
      n_fail++; $display("FAIL scroll_count got=%0d exp=%0d timeout=%b", b_data.size(), 2 * FB, to);
    end else begin
      n_checks++;
      if (b_data[0] !== 24'h000000 || b_user[0] !== 1'b1) begin
        n_fail++; $display("FAIL scroll_frame1_first got=%h/%b exp=000000/1", b_data[0], b_user[0]);
      end
      exp2 = SCROLL ? 24'h010101 : 24'h000000;
      n_checks++;
      if (b_data[FB] !== exp2 || b_user[FB] !== 1'b1) begin
        n_fail++; $display("FAIL scroll_frame2_first got=%h/%b exp=%h/1", b_data[FB], b_user[FB], exp2);
      end
    end
    fc_model = 2;
  endtask

  initial begin
    bar_tab[0] = 24'hFFFFFF; bar_tab[1] = 24'hFFFF00; bar_tab[2] = 24'h00FFFF; bar_tab[3] = 24'h00FF00;
    bar_tab[4] = 24'hFF00FF; bar_tab[5] = 24'hFF0000; bar_tab[6] = 24'h0000FF; bar_tab[7] = 24'h000000;
    test_reset();
    test_bars();
    test_ramp_backpressure();
    test_solid_latch();
    test_en_drop();
    test_reset_mid();
    test_scroll();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
